// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: sequential word fetch, DEPTH-entry {pc,instr} FIFO, redirect flush.
// Optional performance counters are compiled in with `define PREFETCH_PERF_EN.
module instr_prefetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          redirect_i,
  input  logic [31:0]   redirect_pc_i,
  output logic          imem_req_o,
  output logic [31:0]   imem_addr_o,
  input  logic          imem_gnt_i,
  input  logic          imem_rvalid_i,
  input  logic [31:0]   imem_rdata_i,
  output logic          instr_valid_o,
  output logic [31:0]   instr_o,
  output logic [31:0]   instr_pc_o,
  input  logic          instr_ready_i,
  output logic [CW-1:0] count_o
`ifdef PREFETCH_PERF_EN
  ,
  output logic [31:0]   perf_fetch_o,
  output logic [31:0]   perf_flush_o
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SW = CW + 1;

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   pc_mem_q [DEPTH];
  logic [31:0]   pc_mem_d [DEPTH];
  logic [31:0]   ins_mem_q [DEPTH];
  logic [31:0]   ins_mem_d [DEPTH];
  logic          valid_q, valid_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   instr_pc_q, instr_pc_d;

  logic          req_c;
  logic          issue;
  logic          rsp_live;
  logic          push;
  logic          pop;
  logic [31:0]   redir_pc;

  // Next-state logic; head outputs are registered from the post-update FIFO view
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    outst_d    = outst_q;
    discard_d  = discard_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pc_mem_d   = pc_mem_q;
    ins_mem_d  = ins_mem_q;
    push       = 1'b0;

    redir_pc = redirect_pc_i & 32'hFFFF_FFFC;
    req_c    = !rst_i && (state_q == RUN) && !redirect_i &&
               ((SW'(count_q) + SW'(outst_q)) < SW'(DEPTH));
    issue    = req_c && imem_gnt_i;
    rsp_live = imem_rvalid_i && (outst_q != '0);
    pop      = (count_q != '0) && instr_ready_i;

    if (redirect_i) begin
      fetch_pc_d = redir_pc;
      rsp_pc_d   = redir_pc;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      outst_d    = outst_q - CW'(rsp_live);
      discard_d  = outst_d;
      state_d    = (outst_d != '0) ? DRAIN : RUN;
    end else if (state_q == RUN) begin
      push = rsp_live;
      if (issue) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push) begin
        pc_mem_d[wr_ptr_q]  = rsp_pc_q;
        ins_mem_d[wr_ptr_q] = imem_rdata_i;
        wr_ptr_d            = wr_ptr_q + AW'(1);
        rsp_pc_d            = rsp_pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      outst_d = outst_q + CW'(issue) - CW'(push);
    end else if (rsp_live) begin
      discard_d = discard_q - CW'(1);
      outst_d   = outst_q - CW'(1);
      state_d   = (discard_q == CW'(1)) ? RUN : DRAIN;
    end

    valid_d    = (count_d != '0);
    instr_d    = ins_mem_d[rd_ptr_d];
    instr_pc_d = pc_mem_d[rd_ptr_d];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      fetch_pc_q <= '0;
      rsp_pc_q   <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pc_mem_q   <= '{default: '0};
      ins_mem_q  <= '{default: '0};
      valid_q    <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pc_mem_q   <= pc_mem_d;
      ins_mem_q  <= ins_mem_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign imem_req_o    = req_c;
  assign imem_addr_o   = fetch_pc_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign count_o       = count_q;

`ifdef PREFETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_flush_q, perf_flush_d;
  logic [32:0] fetch_sum;
  logic [32:0] flush_sum;
  logic [SW-1:0] flush_inc;

  // Saturating counters; flushes count held entries plus every dropped response
  always_comb begin
    flush_inc = redirect_i ? (SW'(count_q) + SW'(rsp_live))
                           : SW'((state_q == DRAIN) && rsp_live);
    fetch_sum = {1'b0, perf_fetch_q} + 33'(pop && !redirect_i && (state_q == RUN));
    flush_sum = {1'b0, perf_flush_q} + 33'(flush_inc);
    perf_fetch_d = fetch_sum[32] ? 32'hFFFF_FFFF : fetch_sum[31:0];
    perf_flush_d = flush_sum[32] ? 32'hFFFF_FFFF : flush_sum[31:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_fetch_o = perf_fetch_q;
  assign perf_flush_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Scoreboard bench for instr_prefetch_queue: in-order memory model, expected {pc,instr} queue,
// independent pop monitor.
module tb_instr_prefetch_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          redirect_i;
  logic [31:0]   redirect_pc_i;
  logic          imem_req_o;
  logic [31:0]   imem_addr_o;
  logic          imem_gnt_i;
  logic          imem_rvalid_i;
  logic [31:0]   imem_rdata_i;
  logic          instr_valid_o;
  logic [31:0]   instr_o;
  logic [31:0]   instr_pc_o;
  logic          instr_ready_i;
  logic [CW-1:0] count_o;
`ifdef PREFETCH_PERF_EN
  logic [31:0]   perf_fetch_o;
  logic [31:0]   perf_flush_o;
`endif

  instr_prefetch_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i),
    .count_o       (count_o)
`ifdef PREFETCH_PERF_EN
    ,
    .perf_fetch_o  (perf_fetch_o),
    .perf_flush_o  (perf_flush_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_issue = 0;
  logic [63:0] sb_q [$];
  logic [31:0] pend_q [$];
  logic        gnt_en = 1'b0;
  logic        rsp_en = 1'b0;
  logic        sb_track = 1'b0;
  logic [31:0] exp_fetch_pc = 32'h0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive inputs just after the edge, observe issues on the falling edge
  task automatic cycle(input logic redir, input logic [31:0] rpc, input logic rdy);
    @(posedge clk_i);
    #1;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    instr_ready_i = rdy;
    imem_gnt_i    = gnt_en;
    if (rsp_en && pend_q.size() != 0) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = word(pend_q.pop_front());
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
    end
    @(negedge clk_i);
    if (imem_req_o && imem_gnt_i) begin
      chk("fetch_addr", imem_addr_o, exp_fetch_pc);
      pend_q.push_back(imem_addr_o);
      if (sb_track) sb_q.push_back({exp_fetch_pc, word(exp_fetch_pc)});
      exp_fetch_pc = exp_fetch_pc + 32'd4;
      n_issue++;
    end
    if (redir) exp_fetch_pc = rpc & 32'hFFFF_FFFC;
  endtask

  task automatic drain();
    gnt_en = 1'b0;
    rsp_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 32'h0, 1'b1);
      if (!instr_valid_o && !imem_rvalid_i && pend_q.size() == 0) break;
    end
    chk("drained_valid", 32'(instr_valid_o), 32'd0);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  // Monitor: every accepted pop is compared against the scoreboard head
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk_i);
      if (rst_i === 1'b0) begin
        chk("count_bound", 32'(count_o <= CW'(DEPTH)), 32'd1);
        if (instr_valid_o && instr_ready_i && !redirect_i) begin
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_pop: got pc %h expected none", instr_pc_o);
          end else begin
            e = sb_q.pop_front();
            chk("instr_pc", instr_pc_o, e[63:32]);
            chk("instr", instr_o, e[31:0]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1;
    redirect_i = 1'b0; redirect_pc_i = '0; imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0; imem_rdata_i = '0; instr_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_pc", instr_pc_o, 32'd0);
    chk("rst_addr", imem_addr_o, 32'd0);
    chk("rst_req", 32'(imem_req_o), 32'd0);
    #2 rst_i = 1'b0;

    // 1: streaming fetch from PC 0
    gnt_en = 1'b1; rsp_en = 1'b1; sb_track = 1'b1; n_issue = 0;
    repeat (12) cycle(1'b0, 32'h0, 1'b1);
    drain();
    chk("t1_issues", 32'(n_issue), 32'd12);

    // 2: decode stalled, credit limit stops requests at DEPTH
    gnt_en = 1'b1; rsp_en = 1'b1; n_issue = 0;
    repeat (10) cycle(1'b0, 32'h0, 1'b0);
    chk("t2_issues", 32'(n_issue), 32'd4);
    chk("t2_count", 32'(count_o), 32'd4);
    chk("t2_req_off", 32'(imem_req_o), 32'd0);
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0);
    chk("t2_req_reen", 32'(imem_req_o), 32'd1);
    drain();

    // 3: three outstanding, redirect to 0x103, stale responses drained
    sb_track = 1'b0; rsp_en = 1'b0; gnt_en = 1'b1;
    repeat (3) cycle(1'b0, 32'h0, 1'b1);
    gnt_en = 1'b0;
    cycle(1'b1, 32'h0000_0103, 1'b1);
    sb_track = 1'b1; rsp_en = 1'b1; gnt_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 32'h0, 1'b1);
      chk("t3_drain_req", 32'(imem_req_o), 32'd0);
      chk("t3_drain_valid", 32'(instr_valid_o), 32'd0);
    end
    cycle(1'b0, 32'h0, 1'b1);
    chk("t3_req_after", 32'(imem_req_o), 32'd1);
    cycle(1'b0, 32'h0, 1'b1);
    drain();

    // 4: redirect together with pop and rvalid
    sb_track = 1'b0; gnt_en = 1'b1; rsp_en = 1'b1;
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    gnt_en = 1'b0;
    cycle(1'b1, 32'h0000_0200, 1'b1);
    chk("t4_pre_valid", 32'(instr_valid_o), 32'd1);
    chk("t4_pre_rvalid", 32'(imem_rvalid_i), 32'd1);
    sb_track = 1'b1; gnt_en = 1'b1;
    cycle(1'b0, 32'h0, 1'b1);
    chk("t4_valid", 32'(instr_valid_o), 32'd0);
    chk("t4_count", 32'(count_o), 32'd0);
    chk("t4_req", 32'(imem_req_o), 32'd1);
    drain();

    // 5: fetch address wraps at 2^32
    sb_track = 1'b1; gnt_en = 1'b0;
    cycle(1'b1, 32'hFFFF_FFF8, 1'b1);
    n_issue = 0; gnt_en = 1'b1;
    repeat (3) cycle(1'b0, 32'h0, 1'b1);
    drain();
    chk("t5_issues", 32'(n_issue), 32'd3);

    // 6: asynchronous reset with two entries held
    sb_track = 1'b0; gnt_en = 1'b1; rsp_en = 1'b1;
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    gnt_en = 1'b0;
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    chk("t6_held", 32'(count_o), 32'd2);
    #2 rst_i = 1'b1;
    #1;
    chk("t6_count", 32'(count_o), 32'd0);
    chk("t6_valid", 32'(instr_valid_o), 32'd0);
    chk("t6_instr", instr_o, 32'd0);
    chk("t6_pc", instr_pc_o, 32'd0);
    chk("t6_addr", imem_addr_o, 32'd0);
    chk("t6_req", 32'(imem_req_o), 32'd0);
    pend_q.delete();
    exp_fetch_pc = 32'h0;
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    sb_track = 1'b1; gnt_en = 1'b1;
    repeat (2) cycle(1'b0, 32'h0, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
